line_clear_ctl: RTL and testbench



---
 rtl/line_clear_pkg.sv | 38 +++
 rtl/line_score_calc.sv | 33 +++
 rtl/line_clear_ctl.sv | 258 +++++++++++++++++++++++++
 tb/tb_line_clear_ctl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/line_clear_pkg.sv
// Shared definitions for the line-clear sequencer.
//   ROW_ADDR_W   : width of the board RAM row address
//   St*          : sequencer state codes (detect/flash states used only with CLEAR_FLASH_EN)
//   SCORE_*      : base points per pass by number of rows cleared
//   score_base() : maps a cleared-row count to its base points
package line_clear_pkg;

  localparam int unsigned ROW_ADDR_W = 5;

  localparam logic [3:0] StIdle  = 4'd0;
  localparam logic [3:0] StRd    = 4'd1;
  localparam logic [3:0] StWait  = 4'd2;
  localparam logic [3:0] StEval  = 4'd3;
  localparam logic [3:0] StWr    = 4'd4;
  localparam logic [3:0] StFill  = 4'd5;
  localparam logic [3:0] StScore = 4'd6;
  localparam logic [3:0] StDone  = 4'd7;
  localparam logic [3:0] StDrd   = 4'd8;
  localparam logic [3:0] StDwait = 4'd9;
  localparam logic [3:0] StDeval = 4'd10;
  localparam logic [3:0] StFlash = 4'd11;

  localparam logic [15:0] SCORE_1 = 16'd40;
  localparam logic [15:0] SCORE_2 = 16'd100;
  localparam logic [15:0] SCORE_3 = 16'd300;
  localparam logic [15:0] SCORE_4 = 16'd1200;

  function automatic logic [15:0] score_base(input logic [4:0] cnt);
    case (cnt)
      5'd0:    score_base = 16'd0;
      5'd1:    score_base = SCORE_1;
      5'd2:    score_base = SCORE_2;
      5'd3:    score_base = SCORE_3;
      default: score_base = SCORE_4;
    endcase
  endfunction

endpackage

// File: rtl/line_score_calc.sv
// Combinational score and level update for one clear pass.
//   cnt             : rows cleared this pass
//   level           : level before this pass (multiplier base)
//   total_lines     : cumulative lines before this pass
//   score_add       : base(cnt) * (level + 1)
//   total_lines_new : total_lines + cnt, saturating at 1023
//   level_new       : min(MAX_LEVEL, total_lines_new / LINES_PER_LVL)
module line_score_calc
  import line_clear_pkg::*;
#(
  parameter int unsigned LINES_PER_LVL = 10,
  parameter int unsigned MAX_LEVEL     = 15
) (
  input  logic [4:0]  cnt,
  input  logic [3:0]  level,
  input  logic [9:0]  total_lines,
  output logic [15:0] score_add,
  output logic [9:0]  total_lines_new,
  output logic [3:0]  level_new
);

  logic [10:0] sum;
  logic [9:0]  level_raw;

  always_comb begin
    sum             = {1'b0, total_lines} + {6'd0, cnt};
    total_lines_new = sum[10] ? 10'd1023 : sum[9:0];
    level_raw       = total_lines_new / 10'(LINES_PER_LVL);
    level_new       = (level_raw > 10'(MAX_LEVEL)) ? 4'(MAX_LEVEL) : level_raw[3:0];
    score_add       = score_base(cnt) * (16'(level) + 16'd1);
  end

endmodule

// File: rtl/line_clear_ctl.sv
// Line-clear sequencer: after a piece lock, scans the board RAM bottom-up, compacts non-full
// rows downward in place, zero-fills the freed top rows, then scores the pass.
// Optional feature macro: CLEAR_FLASH_EN (detect pass + flash_mask hold before compaction).
// Ports:
//   pclk, rst           : clock, synchronous active-high reset
//   start               : lock pulse, accepted only when idle
//   mem_addr/rd_en/wr_en/wdata, mem_rdata : board RAM (read data valid one cycle after rd_en)
//   busy, done          : pass in progress / end-of-pass pulse
//   lines, score_add    : rows cleared and points of the last pass (held)
//   total_lines, level  : cumulative lines (sat. 1023) and level (0..MAX_LEVEL)
//   flash_mask          : full-row mask during the flash hold (CLEAR_FLASH_EN only)
module line_clear_ctl
  import line_clear_pkg::*;
#(
  parameter int unsigned ROWS          = 22,
  parameter int unsigned ROW_W         = 10,
  parameter int unsigned LINES_PER_LVL = 10,
  parameter int unsigned MAX_LEVEL     = 15
`ifdef CLEAR_FLASH_EN
  ,
  parameter int unsigned FLASH_CYCLES  = 4194304
`endif
) (
  input  logic                  pclk,
  input  logic                  rst,
  input  logic                  start,
  output logic [ROW_ADDR_W-1:0] mem_addr,
  output logic                  mem_rd_en,
  output logic                  mem_wr_en,
  output logic [ROW_W-1:0]      mem_wdata,
  input  logic [ROW_W-1:0]      mem_rdata,
  output logic                  busy,
  output logic                  done,
  output logic [4:0]            lines,
  output logic [15:0]           score_add,
  output logic [9:0]            total_lines,
  output logic [3:0]            level
`ifdef CLEAR_FLASH_EN
  ,
  output logic [ROWS-1:0]       flash_mask
`endif
);

  localparam logic [4:0]        LastRow = 5'(ROWS - 1);
  localparam logic signed [5:0] LastDst = 6'(ROWS - 1);

  logic [3:0]        state_q, state_d;
  logic [4:0]        src_q, src_d;
  // Signed so the final FILL decrement lands on -1 instead of wrapping to a valid row.
  logic signed [5:0] dst_q, dst_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [4:0]        lines_q, lines_d;
  logic [15:0]       score_q, score_d;
  logic [9:0]        total_q, total_d;
  logic [3:0]        level_q, level_d;
  logic              advance;
`ifdef CLEAR_FLASH_EN
  logic [ROWS-1:0]   mask_q, mask_d;
  logic [31:0]       flash_cnt_q, flash_cnt_d;
`endif

  logic [15:0] calc_score;
  logic [9:0]  calc_total;
  logic [3:0]  calc_level;

  line_score_calc #(
    .LINES_PER_LVL(LINES_PER_LVL),
    .MAX_LEVEL    (MAX_LEVEL)
  ) u_score (
    .cnt            (cnt_q),
    .level          (level_q),
    .total_lines    (total_q),
    .score_add      (calc_score),
    .total_lines_new(calc_total),
    .level_new      (calc_level)
  );

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    lines_d = lines_q;
    score_d = score_q;
    total_d = total_q;
    level_d = level_q;
    advance = 1'b0;
`ifdef CLEAR_FLASH_EN
    mask_d      = mask_q;
    flash_cnt_d = flash_cnt_q;
`endif
    case (state_q)
      StIdle: begin
        if (start) begin
          src_d = LastRow;
          dst_d = LastDst;
          cnt_d = '0;
`ifdef CLEAR_FLASH_EN
          mask_d  = '0;
          state_d = StDrd;
`else
          state_d = StRd;
`endif
        end
      end
      StRd:   state_d = StWait;
      StWait: begin
        row_d   = mem_rdata;
        state_d = StEval;
      end
      StEval: begin
        if (&row_q) begin
          cnt_d   = cnt_q + 5'd1;
          advance = 1'b1;
        end else if (dst_q == $signed({1'b0, src_q})) begin
          dst_d   = dst_q - 6'sd1;
          advance = 1'b1;
        end else begin
          state_d = StWr;
        end
      end
      StWr: begin
        dst_d   = dst_q - 6'sd1;
        advance = 1'b1;
      end
      StFill: begin
        // Compaction leaves dst at cnt-1, so this runs exactly cnt times.
        dst_d = dst_q - 6'sd1;
        if (dst_q == 6'sd0) state_d = StScore;
      end
      StScore: begin
        lines_d = cnt_q;
        score_d = calc_score;
        total_d = calc_total;
        level_d = calc_level;
        state_d = StDone;
      end
      StDone: begin
`ifdef CLEAR_FLASH_EN
        mask_d = '0;
`endif
        state_d = StIdle;
      end
`ifdef CLEAR_FLASH_EN
      StDrd:   state_d = StDwait;
      StDwait: begin
        row_d   = mem_rdata;
        state_d = StDeval;
      end
      StDeval: begin
        if (&row_q) mask_d[src_q] = 1'b1;
        if (src_q == '0) begin
          if (mask_d != '0) begin
            flash_cnt_d = '0;
            state_d     = StFlash;
          end else begin
            lines_d = '0;
            score_d = '0;
            state_d = StDone;
          end
        end else begin
          src_d   = src_q - 5'd1;
          state_d = StDrd;
        end
      end
      StFlash: begin
        if (flash_cnt_q == 32'(FLASH_CYCLES - 1)) begin
          src_d   = LastRow;
          dst_d   = LastDst;
          cnt_d   = '0;
          state_d = StRd;
        end else begin
          flash_cnt_d = flash_cnt_q + 32'd1;
        end
      end
`endif
      default: state_d = StIdle;
    endcase

    // Shared end-of-row step for EVAL (no write needed) and WR.
    if (advance) begin
      if (src_q == '0) begin
        state_d = (cnt_d != '0) ? StFill : StScore;
      end else begin
        src_d   = src_q - 5'd1;
        state_d = StRd;
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q <= StIdle;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      row_q   <= '0;
      lines_q <= '0;
      score_q <= '0;
      total_q <= '0;
      level_q <= '0;
`ifdef CLEAR_FLASH_EN
      mask_q      <= '0;
      flash_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      lines_q <= lines_d;
      score_q <= score_d;
      total_q <= total_d;
      level_q <= level_d;
`ifdef CLEAR_FLASH_EN
      mask_q      <= mask_d;
      flash_cnt_q <= flash_cnt_d;
`endif
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    mem_wdata = '0;
    case (state_q)
      StRd, StDrd: begin
        mem_addr  = src_q;
        mem_rd_en = 1'b1;
      end
      StWr: begin
        mem_addr  = dst_q[4:0];
        mem_wdata = row_q;
        mem_wr_en = 1'b1;
      end
      StFill: begin
        mem_addr  = dst_q[4:0];
        mem_wr_en = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy        = (state_q != StIdle);
  assign done        = (state_q == StDone);
  assign lines       = lines_q;
  assign score_add   = score_q;
  assign total_lines = total_q;
  assign level       = level_q;
`ifdef CLEAR_FLASH_EN
  assign flash_mask  = mask_q;
`endif

endmodule

// File: tb/tb_line_clear_ctl.sv
// Self-checking bench for line_clear_ctl: behavioural board/score model plus a per-cycle
// output compare process, driven by directed and random boards.
module tb_line_clear_ctl;

  localparam int ROWS  = 22;
  localparam int ROW_W = 10;
  localparam logic [ROW_W-1:0] FULL = '1;

  logic             pclk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [4:0]       mem_addr;
  logic             mem_rd_en, mem_wr_en;
  logic [ROW_W-1:0] mem_wdata;
  logic [ROW_W-1:0] mem_rdata = '0;
  logic             busy, done;
  logic [4:0]       lines;
  logic [15:0]      score_add;
  logic [9:0]       total_lines;
  logic [3:0]       level;

  line_clear_ctl #(
    .ROWS         (ROWS),
    .ROW_W        (ROW_W),
    .LINES_PER_LVL(10),
    .MAX_LEVEL    (15)
  ) dut (
    .pclk       (pclk),
    .rst        (rst),
    .start      (start),
    .mem_addr   (mem_addr),
    .mem_rd_en  (mem_rd_en),
    .mem_wr_en  (mem_wr_en),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .busy       (busy),
    .done       (done),
    .lines      (lines),
    .score_add  (score_add),
    .total_lines(total_lines),
    .level      (level)
  );

  always #5 pclk = ~pclk;

  // Board RAM with a whole-array preload path.
  logic [ROW_W-1:0] mem        [ROWS];
  logic [ROW_W-1:0] init_board [ROWS];
  logic [ROW_W-1:0] exp_board  [ROWS];
  logic             load = 1'b0;

  always @(posedge pclk) begin
    if (load) mem <= init_board;
    else if (mem_wr_en && mem_addr < ROWS) mem[mem_addr] <= mem_wdata;
    if (mem_rd_en && mem_addr < ROWS) mem_rdata <= mem[mem_addr];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Committed model state (after the last done) and pending results of the running pass.
  int m_total = 0, m_level = 0, m_lines = 0, m_score = 0;
  int p_total = 0, p_level = 0, p_lines = 0, p_score = 0;
  int busy_cnt = 0, wr_cnt = 0, done_cnt = 0;
  int last_busy = 0, last_wr = 0;

  function automatic int base_pts(input int c);
    case (c)
      0:       return 0;
      1:       return 40;
      2:       return 100;
      3:       return 300;
      default: return 1200;
    endcase
  endfunction

  function automatic logic [ROW_W-1:0] rand_row();
    if ($urandom_range(0, 3) == 0) return FULL;
    return ROW_W'($urandom_range(0, 1022));
  endfunction

  // Expected board: surviving rows keep their order and sink to the bottom.
  task automatic model_pass(output int moved, output int cnt);
    int idx;
    idx = ROWS - 1; moved = 0; cnt = 0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (init_board[r] == FULL) cnt++;
      else begin
        exp_board[idx] = init_board[r];
        if (idx != r) moved++;
        idx--;
      end
    end
    for (int r = idx; r >= 0; r--) exp_board[r] = '0;
    p_lines = cnt;
    p_score = base_pts(cnt) * (m_level + 1);
    p_total = (m_total + cnt > 1023) ? 1023 : m_total + cnt;
    p_level = (p_total / 10 > 15) ? 15 : p_total / 10;
  endtask

  // Per-cycle compare of DUT outputs against the model.
  initial forever begin
    @(negedge pclk);
    if (rst) begin
      m_total = 0; m_level = 0; m_lines = 0; m_score = 0;
    end else begin
      chk("rd_wr_exclusive", longint'(mem_rd_en & mem_wr_en), 0);
      if (busy) busy_cnt++;
      if (mem_wr_en) wr_cnt++;
      if (done) begin
        done_cnt++;
        chk("done_busy", longint'(busy), 1);
        chk("done_lines", lines, p_lines);
        chk("done_score", score_add, p_score);
        chk("done_total", total_lines, p_total);
        chk("done_level", level, p_level);
        m_total = p_total; m_level = p_level; m_lines = p_lines; m_score = p_score;
      end else begin
        chk("hold_lines", lines, m_lines);
        chk("hold_score", score_add, m_score);
        chk("hold_total", total_lines, m_total);
        chk("hold_level", level, m_level);
        if (!busy) chk("idle_mem", longint'(mem_rd_en | mem_wr_en), 0);
      end
    end
  end

  task automatic run_pass(input string tag, input bit dbl_start);
    int moved, cnt, b0, w0, d0, n;
    @(posedge pclk); #1 load = 1'b1;
    @(posedge pclk); #1 load = 1'b0;
    model_pass(moved, cnt);
    b0 = busy_cnt; w0 = wr_cnt; d0 = done_cnt;
    start = 1'b1;
    @(posedge pclk); #1 start = 1'b0;
    n = 0;
    while (done_cnt == d0 && n < 400) begin
      @(posedge pclk); #1;
      n++;
      start = (dbl_start && n == 10);
    end
    start = 1'b0;
    if (n >= 400) begin
      chk({tag, "_timeout"}, 1, 0);
    end else begin
      repeat (3) @(posedge pclk);
      #1;
      last_busy = busy_cnt - b0;
      last_wr   = wr_cnt - w0;
      chk({tag, "_busy_cycles"}, last_busy, 3 * ROWS + moved + cnt + 2);
      chk({tag, "_writes"}, last_wr, moved + cnt);
      chk({tag, "_done_count"}, done_cnt - d0, 1);
      for (int r = 0; r < ROWS; r++)
        chk($sformatf("%s_row%0d", tag, r), mem[r], exp_board[r]);
    end
  endtask

  task automatic clear_init();
    for (int r = 0; r < ROWS; r++) init_board[r] = '0;
  endtask

  initial begin
    logic [ROW_W-1:0] a, b, r17;
    int guard, n;
    clear_init();
    rst = 1'b1;
    repeat (3) @(posedge pclk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_lines", lines, 0);
    chk("rst_score", score_add, 0);
    chk("rst_total", total_lines, 0);
    chk("rst_level", level, 0);
    chk("rst_wr", mem_wr_en, 0);
    rst = 1'b0;

    // Empty board: no writes, 68 busy cycles.
    run_pass("empty", 1'b0);
    chk("empty_cycles_lit", last_busy, 68);
    chk("empty_writes_lit", last_wr, 0);
    chk("empty_score_lit", score_add, 0);
    chk("empty_level_lit", level, 0);

    clear_init();
    init_board[21] = FULL;
    init_board[20] = 10'b0000010000;
    run_pass("single", 1'b0);
    chk("single_row21_lit", mem[21], 10'b0000010000);
    chk("single_row20_lit", mem[20], 0);
    chk("single_lines_lit", lines, 1);
    chk("single_score_lit", score_add, 40);
    chk("single_total_lit", total_lines, 1);

    a = ROW_W'($urandom_range(1, 1022));
    b = ROW_W'($urandom_range(1, 1022));
    clear_init();
    init_board[21] = FULL; init_board[20] = a;
    init_board[19] = FULL; init_board[18] = b;
    run_pass("gap", 1'b0);
    chk("gap_row21_lit", mem[21], a);
    chk("gap_row20_lit", mem[20], b);
    chk("gap_row19_lit", mem[19], 0);
    chk("gap_lines_lit", lines, 2);
    chk("gap_score_lit", score_add, 100);

    clear_init();
    for (int r = 16; r < ROWS; r++) init_board[r] = FULL;
    run_pass("six", 1'b0);
    chk("six_total_lit", total_lines, 9);

    // Level step: old level scores the pass.
    clear_init();
    init_board[21] = FULL;
    run_pass("lvlup", 1'b0);
    chk("lvlup_total_lit", total_lines, 10);
    chk("lvlup_level_lit", level, 1);
    chk("lvlup_score_lit", score_add, 40);

    clear_init();
    for (int r = 12; r < ROWS; r++) init_board[r] = FULL;
    run_pass("ten", 1'b0);
    chk("ten_score_lit", score_add, 2400);
    chk("ten_level_lit", level, 2);

    for (int r = 0; r < 18; r++) init_board[r] = ROW_W'($urandom_range(0, 1022));
    for (int r = 18; r < ROWS; r++) init_board[r] = FULL;
    r17 = init_board[17];
    run_pass("four", 1'b0);
    chk("four_lines_lit", lines, 4);
    chk("four_score_lit", score_add, 3600);
    chk("four_row21_lit", mem[21], r17);
    chk("four_row0_lit", mem[0], 0);

    for (int i = 0; i < 12; i++) begin
      for (int r = 0; r < ROWS; r++) init_board[r] = rand_row();
      run_pass($sformatf("rand%0d", i), i == 3);
    end

    // Saturate total_lines with all-full boards.
    for (int r = 0; r < ROWS; r++) init_board[r] = FULL;
    guard = 0;
    while (m_total < 1023 && guard < 60) begin
      run_pass($sformatf("sat%0d", guard), 1'b0);
      guard++;
    end
    chk("sat_level_lit", level, 15);
    chk("sat_total_lit", total_lines, 1023);
    run_pass("satx", 1'b0);
    chk("satx_total_lit", total_lines, 1023);
    chk("satx_score_lit", score_add, 19200);

    // Reset during FILL (rows 20,21 full: FILL is the only writer of row 1).
    clear_init();
    init_board[21] = FULL; init_board[20] = FULL;
    @(posedge pclk); #1 load = 1'b1;
    @(posedge pclk); #1 load = 1'b0;
    start = 1'b1;
    @(posedge pclk); #1 start = 1'b0;
    n = 0;
    while (!(mem_wr_en && mem_addr == 5'd1) && n < 400) begin
      @(posedge pclk); #1;
      n++;
    end
    chk("rstfill_reached", longint'(n < 400), 1);
    rst = 1'b1;
    @(posedge pclk); #1;
    chk("rstfill_busy", busy, 0);
    chk("rstfill_done", done, 0);
    chk("rstfill_lines", lines, 0);
    chk("rstfill_score", score_add, 0);
    chk("rstfill_total", total_lines, 0);
    chk("rstfill_level", level, 0);
    chk("rstfill_wr", mem_wr_en, 0);
    @(posedge pclk); #1 rst = 1'b0;

    clear_init();
    init_board[21] = FULL;
    init_board[0]  = 10'b1000000001;
    run_pass("postrst", 1'b0);
    chk("postrst_score_lit", score_add, 40);
    chk("postrst_total_lit", total_lines, 1);
    chk("postrst_row1_lit", mem[1], 10'b1000000001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
